// File: rtl/formula_arbiter.sv
// formula_arbiter: round-robin sharing of one pipelined formula unit among NREQ requesters, with id-tagged result steering.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   arb_en              grant enable (in-flight operations always drain)
//   req_valid/req_ready per-requester handshake, ready is a one-hot grant
//   req_a..req_d        packed operands, requester i at [i*N +: N]
//   f_rstn, f_valid, f_a..f_d, f_o_valid, f_q   formula instance interface
//   rsp_valid, rsp_id, rsp_q                    one-cycle tagged result
//   busy, err           activity flag, sticky tag/valid mismatch
// Optional: FORMULA_ARB_STATS_EN adds stat_grants (per-requester transfers) and stat_drops (untagged results).
module formula_arbiter #(
    parameter int N     = 8,
    parameter int NREQ  = 4,
    parameter int LAT   = 5,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    input  logic [NREQ*N-1:0]         req_c,
    input  logic [NREQ*N-1:0]         req_d,
    output logic                      f_rstn,
    output logic                      f_valid,
    output logic [N-1:0]              f_a,
    output logic [N-1:0]              f_b,
    output logic [N-1:0]              f_c,
    output logic [N-1:0]              f_d,
    input  logic                      f_o_valid,
    input  logic [N-1:0]              f_q,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_q,
    output logic                      busy,
`ifdef FORMULA_ARB_STATS_EN
    output logic [NREQ*CNT_W-1:0]     stat_grants,
    output logic [CNT_W-1:0]          stat_drops,
`endif
    output logic                      err
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [IW-1:0]   r_ptr;
    logic            r_f_valid;
    logic [N-1:0]    r_f_a, r_f_b, r_f_c, r_f_d;
    logic [IW-1:0]   r_f_id;
    logic [LAT-1:0]  r_tag_v;
    logic [IW-1:0]   r_tag_id [LAT];
    logic [NREQ-1:0] r_rsp_valid;
    logic [IW-1:0]   r_rsp_id;
    logic [N-1:0]    r_rsp_q;
    logic            r_err;

    int              w_idx;
    logic            w_hit;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_nxt;
    logic [NREQ-1:0] w_gnt;
    logic            w_xfer;
    logic            w_rsp;
    logic            w_mis;

    // Scan from the highest offset down so the requester closest to the pointer wins last.
    always_comb begin
        w_idx = 0;
        w_hit = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            w_idx = (w_idx >= NREQ) ? w_idx - NREQ : w_idx;
            if (req_valid[w_idx]) begin
                w_hit = 1'b1;
                w_win = IW'(w_idx);
            end
        end
    end

    assign w_gnt     = (w_hit && arb_en && !rst) ? ONE << w_win : '0;
    assign w_xfer    = |w_gnt;
    assign w_nxt     = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    // The tag pipe mirrors the formula latency, so its last stage must agree with f_o_valid.
    assign w_rsp     = f_o_valid & r_tag_v[LAT-1];
    assign w_mis     = f_o_valid ^ r_tag_v[LAT-1];

    assign req_ready = w_gnt;
    assign f_rstn    = ~rst;
    assign f_valid   = r_f_valid;
    assign f_a       = r_f_a;
    assign f_b       = r_f_b;
    assign f_c       = r_f_c;
    assign f_d       = r_f_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign err       = r_err;
    assign busy      = r_f_valid | (|r_tag_v) | (|r_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_f_valid   <= 1'b0;
            r_f_a       <= '0;
            r_f_b       <= '0;
            r_f_c       <= '0;
            r_f_d       <= '0;
            r_f_id      <= '0;
            r_tag_v     <= '0;
            for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_q     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_f_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr  <= w_nxt;
                r_f_a  <= req_a[w_win*N +: N];
                r_f_b  <= req_b[w_win*N +: N];
                r_f_c  <= req_c[w_win*N +: N];
                r_f_d  <= req_d[w_win*N +: N];
                r_f_id <= w_win;
            end
            r_tag_v     <= {r_tag_v[LAT-2:0], r_f_valid};
            r_tag_id[0] <= r_f_id;
            for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
            r_rsp_valid <= w_rsp ? ONE << r_tag_id[LAT-1] : '0;
            if (w_rsp) begin
                r_rsp_id <= r_tag_id[LAT-1];
                r_rsp_q  <= f_q;
            end
            if (w_mis) r_err <= 1'b1;
        end
    end

`ifdef FORMULA_ARB_STATS_EN
    logic [CNT_W-1:0] r_grants [NREQ];
    logic [CNT_W-1:0] r_drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) r_grants[i] <= '0;
            r_drops <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (w_gnt[i] && r_grants[i] != '1) r_grants[i] <= r_grants[i] + 1'b1;
            if (f_o_valid && !r_tag_v[LAT-1] && r_drops != '1) r_drops <= r_drops + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*CNT_W +: CNT_W] = r_grants[g];
    end
    assign stat_drops = r_drops;
`endif
endmodule

// File: tb/tb_formula_arbiter.sv
// tb_formula_arbiter: directed scoreboard bench for formula_arbiter driving a behavioural formula pipeline.
module tb_formula_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic        f_rstn, f_valid;
    logic [7:0]  f_a, f_b, f_c, f_d;
    logic        f_o_valid;
    logic [7:0]  f_q;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_q;
    logic        busy, err;

    formula_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .f_rstn(f_rstn), .f_valid(f_valid),
        .f_a(f_a), .f_b(f_b), .f_c(f_c), .f_d(f_d),
        .f_o_valid(f_o_valid), .f_q(f_q),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fml(logic signed [7:0] a, logic signed [7:0] b,
                                       logic signed [7:0] c, logic signed [7:0] d);
        int r;
        r = ((int'(a) - int'(b)) * (1 + 3 * int'(c)) - 4 * int'(d)) >>> 1;
        return (r > 127) ? 8'h7f : (r < -128) ? 8'h80 : r[7:0];
    endfunction

    logic [LAT-1:0] fm_v = '0;
    logic [7:0]     fm_q [LAT];
    logic           force_ov = 1'b0;

    always @(posedge clk) begin
        if (!f_rstn) fm_v <= '0;
        else fm_v <= {fm_v[LAT-2:0], f_valid};
        fm_q[0] <= fml(f_a, f_b, f_c, f_d);
        for (int i = 1; i < LAT; i++) fm_q[i] <= fm_q[i-1];
    end

    assign f_o_valid = fm_v[LAT-1] | force_ov;
    assign f_q       = fm_q[LAT-1];

    typedef struct {int id; int q;} exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int   eq [4];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, prev_rsp = -10, run_len = 0, lat = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst && rsp_valid != 0) begin
            run_len  = (prev_rsp == cyc - 1) ? run_len + 1 : 1;
            prev_rsp = cyc;
            if (sbq.size() == 0) chk("unexpected_rsp", int'(rsp_valid), 0);
            else begin
                mon_e = sbq.pop_front();
                chk("rsp_id", int'(rsp_id), mon_e.id);
                chk("rsp_q", int'($signed(rsp_q)), mon_e.q);
                chk("rsp_onehot", int'(rsp_valid), 1 << mon_e.id);
            end
        end
    end

    task automatic set_op(int i, int a, int b, int c, int d);
        req_a[i*8 +: 8] = 8'(a);
        req_b[i*8 +: 8] = 8'(b);
        req_c[i*8 +: 8] = 8'(c);
        req_d[i*8 +: 8] = 8'(d);
    endtask

    task automatic step(logic [3:0] exp_rdy, bit push);
        #1;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        if (push)
            for (int i = 0; i < 4; i++)
                if (exp_rdy[i]) sbq.push_back('{i, eq[i]});
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
        @(negedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic std_ops();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 2 * (i + 1), 0, 0, 0);
            eq[i] = i + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        arb_en = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        #1;
        chk("rst_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("rst_f_valid", int'(f_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_q", int'(rsp_q), 0);
        chk("rst_f_a", int'(f_a), 0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        set_op(0, 1, 2, 3, 4);
        eq[0] = -13;
        req_valid = 4'b0001;
        step(4'b0001, 1);
        req_valid = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid[0]) begin
                lat = i;
                break;
            end
        end
        chk("t1_latency", lat, 6);
        chk("t1_f_hold", int'(f_a), 1);
        drain();

        do_reset(2);
        std_ops();
        req_valid = 4'hf;
        for (int c = 0; c < 12; c++) step(4'(1 << (c % 4)), 1);
        req_valid = '0;
        drain();
        chk("t2_back_to_back", run_len, 12);

        req_valid = 4'b0001;
        step(4'b0001, 1);
        req_valid = 4'b0110;
        step(4'b0010, 1);
        step(4'b0100, 1);
        req_valid = 4'b0010;
        step(4'b0010, 1);
        req_valid = '0;
        drain();

        set_op(3, 120, -25, 7, 6);
        eq[3] = 127;
        req_valid = 4'b1000;
        step(4'b1000, 1);
        set_op(3, -120, 25, 7, 6);
        eq[3] = -128;
        step(4'b1000, 1);
        set_op(0, 10, 20, 5, 10);
        eq[0] = -100;
        req_valid = 4'b0001;
        step(4'b0001, 1);
        req_valid = '0;
        drain();

        do_reset(2);
        std_ops();
        req_valid = 4'b0111;
        step(4'b0001, 1);
        step(4'b0010, 1);
        step(4'b0100, 1);
        arb_en = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("t5_busy_inflight", int'(busy), 1);
        for (int c = 0; c < 10; c++) step(4'b0000, 0);
        chk("t5_drained", sbq.size(), 0);
        chk("t5_busy_after", int'(busy), 0);
        arb_en = 1'b1;
        step(4'b1000, 1);
        req_valid = 4'b0001;
        step(4'b0001, 1);
        req_valid = '0;
        drain();

        force_ov = 1'b1;
        @(negedge clk);
        force_ov = 1'b0;
        #1;
        chk("t6_err_set", int'(err), 1);
        chk("t6_no_rsp", int'(rsp_valid), 0);
        repeat (5) @(negedge clk);
        chk("t6_err_sticky", int'(err), 1);
        req_valid = 4'b0111;
        step(4'b0010, 0);
        step(4'b0100, 0);
        step(4'b0001, 0);
        rst = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("t6_rst_ready", int'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_err", int'(err), 0);
        rst = 1'b0;
        req_valid = '0;
        repeat (12) @(negedge clk);
        chk("t6_quiet_busy", int'(busy), 0);
        chk("t6_quiet_err", int'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
